// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC add-column scheduler slice.
//   state_e         : scheduler FSM state encoding
//   SIZE_DEFAULT    : default number of accumulator columns
//   LATENCY_DEFAULT : default FP add column latency (issue -> write-back)
//   K_W_DEFAULT     : default width of the pass-count input
//   COL_W           : column index width for the default column count
//   col_width()     : column index width for any column count (min 1 bit)
// -----------------------------------------------------------------------------
package mac_pkg;

  localparam int SIZE_DEFAULT    = 16;
  localparam int LATENCY_DEFAULT = 3;
  localparam int K_W_DEFAULT     = 8;
  localparam int COL_W           = $clog2(SIZE_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // A single-column build still needs a 1-bit index bus.
  function automatic int col_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/mac_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// mac_issue_scoreboard
// One in-flight bit per accumulator column. A column's bit is set when it is
// issued into the add column and cleared when its write-back is accepted.
//   clk, rstn : clock, asynchronous active-low reset
//   freeze    : hold every bit (add column stalled)
//   set_en    : issue this cycle; set_col selects the bit to set
//   clr_en    : write-back this cycle; clr_col selects the bit to clear
//   inflight  : registered in-flight vector
// -----------------------------------------------------------------------------
module mac_issue_scoreboard
  import mac_pkg::*;
#(
  parameter int  SIZE  = SIZE_DEFAULT,
  localparam int COL_W = col_width(SIZE)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             freeze,
  input  logic             set_en,
  input  logic [COL_W-1:0] set_col,
  input  logic             clr_en,
  input  logic [COL_W-1:0] clr_col,
  output logic [SIZE-1:0]  inflight
);

  logic [SIZE-1:0] set_mask;
  logic [SIZE-1:0] clr_mask;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_col] = 1'b1;
    if (clr_en) clr_mask[clr_col] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering. This vector is a handful of
  // flag flops, not a RAM, so it is reset along with the control state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= '0;
    end else if (!freeze) begin
      // An issue never targets a column that is clearing this cycle (it is
      // blocked while its bit is set), so set and clear cannot collide.
      inflight <= (inflight & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/mac_add_scheduler.sv
// -----------------------------------------------------------------------------
// mac_add_scheduler
// Feeds multiplier product vectors into a pipelined FP add column, one
// accumulator column per issue, for k_len passes over all SIZE columns.
// A column is never re-issued while its previous sum is still in the add
// column (no bypass), and col_stall freezes the whole scheduler together
// with the add column.
//   clk, rstn                          : clock, asynchronous active-low reset
//   start, k_len                       : job request and pass count
//   busy, done                         : job in progress / final result out
//   prod_valid, prod_ready             : product vector handshake
//   col_stall                          : add column stall (freezes scheduler)
//   issue_valid/col/first/last         : add column issue controls
//   wb_valid_in, wb_col_in, wb_done_in : add column outputs
//   acc_we, acc_waddr                  : accumulator write-back
// -----------------------------------------------------------------------------
module mac_add_scheduler
  import mac_pkg::*;
#(
  parameter int  SIZE    = SIZE_DEFAULT,
  parameter int  LATENCY = LATENCY_DEFAULT,
  parameter int  K_W     = K_W_DEFAULT,
  localparam int COL_W   = col_width(SIZE)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [K_W-1:0]   k_len,
  output logic             busy,
  output logic             done,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic             col_stall,
  output logic             issue_valid,
  output logic [COL_W-1:0] issue_col,
  output logic             issue_first,
  output logic             issue_last,
  input  logic             wb_valid_in,
  input  logic [COL_W-1:0] wb_col_in,
  input  logic             wb_done_in,
  output logic             acc_we,
  output logic [COL_W-1:0] acc_waddr
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SIZE - 1);

  // The scheduler itself is latency-agnostic (the scoreboard tracks real
  // write-backs); LATENCY only has to describe a realisable add column.
  if (LATENCY < 1) begin : g_latency_check
    $error("mac_add_scheduler: LATENCY must be at least 1");
  end

  state_e           state;
  logic [COL_W-1:0] col;
  logic [K_W-1:0]   pass;
  logic [K_W-1:0]   k_q;
  logic [SIZE-1:0]  inflight;
  logic             fire;
  logic             last_issue;

  // Issue path is purely combinational so the add column sees the issue in
  // the same cycle the product is accepted.
  assign prod_ready  = (state == ST_RUN) && !col_stall && !inflight[col];
  assign fire        = prod_valid && prod_ready;
  assign last_issue  = (col == LAST_COL) && (pass == k_q - K_W'(1));

  assign issue_valid = fire;
  assign issue_col   = col;
  assign issue_first = fire && (pass == '0);
  assign issue_last  = fire && last_issue;

  assign acc_we      = wb_valid_in && !col_stall;
  assign acc_waddr   = wb_col_in;

  mac_issue_scoreboard #(
    .SIZE (SIZE)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .freeze   (col_stall),
    .set_en   (fire),
    .set_col  (col),
    .clr_en   (wb_valid_in),
    .clr_col  (wb_col_in),
    .inflight (inflight)
  );

  // Control FSM with registered busy/done. A stall holds every register,
  // including the state, so the scheduler and add column stay in lockstep.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      col   <= '0;
      pass  <= '0;
      k_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (!col_stall) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (k_len == '0) begin
              // Empty job: nothing to issue, report completion next cycle.
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              k_q   <= k_len;
              col   <= '0;
              pass  <= '0;
            end
          end
        end
        ST_RUN: begin
          if (fire) begin
            if (col == LAST_COL) begin
              col  <= '0;
              pass <= pass + K_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
            if (last_issue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The last issue carries the add column done flag; its write-back
          // is the final result leaving the column.
          if (wb_valid_in && wb_done_in) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_add_scheduler.md
MAC_ADD_SCHEDULER -- requirements
Module: mac_add_scheduler

Interface
REQ-001 Parameter SIZE, default 16: number of accumulator columns; COL_W = $clog2(SIZE).
REQ-002 Parameter LATENCY, default 3: cycles from issue into the FP add column to its result/valid/col/done outputs.
REQ-003 Parameter K_W, default 8: width of the pass-count input.
REQ-004 One clock, clk; reset rstn is asynchronous, active-low.
REQ-005 clk  in  1  system clock.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins a job when idle.
REQ-008 k_len  in  K_W  number of accumulation passes over all SIZE columns; sampled on accepted start.
REQ-009 busy  out  1  high from accepted start until the done pulse, inclusive.
REQ-010 done  out  1  one-cycle pulse; final column result has left the add column.
REQ-011 prod_valid  in  1  multiplier presents a product vector for the current column.
REQ-012 prod_ready  out  1  scheduler accepts that vector this cycle.
REQ-013 col_stall  in  1  same net that drives the add column stall; freezes the scheduler.
REQ-014 issue_valid  out  1  drives the add column valid input.
REQ-015 issue_col  out  COL_W  drives the add column column-index input; also selects the accumulator read.
REQ-016 issue_first  out  1  pass 0: accumulator operand forced to +0.0.
REQ-017 issue_last  out  1  drives the add column done input on the final issue.
REQ-018 wb_valid_in / wb_col_in / wb_done_in  in  1 / COL_W / 1  add column valid, column and done outputs.
REQ-019 acc_we / acc_waddr  out  1 / COL_W  accumulator write-back strobe and address.

Function
REQ-020 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE -> RUN on start with k_len != 0; latch k_len; clear col and pass counters.
REQ-022 IDLE -> DONE on start with k_len == 0; no issue occurs; done pulses the following cycle.
REQ-023 Start while not IDLE is ignored.
REQ-024 prod_ready = (state == RUN) && !col_stall && !inflight[col]; issue fires when prod_valid && prod_ready.
REQ-025 On issue: issue_valid = 1, issue_col = col, issue_first = (pass == 0), issue_last = (col == SIZE-1 && pass == k_len-1); all combinational, same cycle.
REQ-026 After issue: col increments; on wrap from SIZE-1 to 0, pass increments; the final issue moves RUN -> DRAIN.
REQ-027 Scoreboard inflight[SIZE]: bit col is set on issue; bit wb_col_in is cleared on wb_valid_in && !col_stall.
REQ-028 No bypass: issue to column j is blocked in any cycle where inflight[j] is registered set, including the cycle its write-back arrives.
REQ-029 acc_we = wb_valid_in && !col_stall; acc_waddr = wb_col_in.
REQ-030 DRAIN -> DONE when wb_valid_in && wb_done_in && !col_stall; DONE -> IDLE after one cycle with done = 1.
REQ-031 While col_stall = 1, no state, counter or scoreboard register changes; prod_ready, issue_valid and acc_we are 0.
REQ-032 When issue does not fire, issue_valid, issue_first and issue_last are 0.

Reset
REQ-033 On rstn low (asynchronous): state = IDLE; counters = 0; inflight = 0; busy, done, prod_ready, issue_valid, acc_we = 0.
REQ-034 Reset mid-job aborts the job without a done pulse; the add column is reset by the same rstn.

Structure
REQ-035 Shared package mac_pkg holds the state enum, SIZE/LATENCY defaults and COL_W.
REQ-036 Sub-module mac_issue_scoreboard holds the inflight bit vector with set/clear/freeze ports.

Verification
REQ-037 k_len = 2, prod_valid held high, no stall -> 32 issues with cols 0..15 twice; issue_first on the first 16 only; issue_last on issue 32; done exactly once, LATENCY+1 cycles after the last issue.
REQ-038 SIZE = 2, LATENCY = 3, k_len = 3 -> col 0 is re-issued only in the cycle after its write-back; inflight never has a column issued twice in flight.
REQ-039 col_stall high for 5 cycles mid-RUN -> no counter, scoreboard or acc_we change; sequence resumes unchanged afterwards.
REQ-040 start with k_len = 0 -> zero issues; busy high for 1 cycle; done pulse 1 cycle after start.
REQ-041 rstn asserted after 7 issues, then released and a new start with k_len = 1 -> issues restart at col 0 with issue_first = 1; no stale done pulse.
REQ-042 Second start while busy -> ignored; k_len is unchanged and exactly one done pulse occurs.
